// File: rtl/uart_time_reporter.sv
// Serialises the pomodoro countdown as 8N1 ASCII lines ("MM:SS\r\n" or "DONE\r\n") on tx.
// Optional macro REPORT_AUTO_SEC_EN: emit a status line automatically on every seconds change.
module uart_time_reporter #(
  parameter int BIT_TICKS = 10416
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] minutes,
  input  logic [6:0] seconds,
  input  logic       done,
  input  logic       send,
  output logic       tx,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      state, state_nxt;
  logic [15:0] tick_cnt;
  logic [2:0]  bit_idx;
  logic [2:0]  byte_idx;
  logic        send_pend, done_pend, done_q;
  logic        line_done;
  logic [6:0]  min_snap, sec_snap;
  logic [7:0]  cur_byte;
  logic        send_set, done_set;
  logic        start_done_line, start_send_line, start_line;
  logic        tick_end, last_byte;

  function automatic logic [6:0] sat99(input logic [6:0] v);
    return (v > 7'd99) ? 7'd99 : v;
  endfunction

  function automatic logic [7:0] ascii_tens(input logic [6:0] v);
    return 8'h30 + 8'(v / 7'd10);
  endfunction

  function automatic logic [7:0] ascii_ones(input logic [6:0] v);
    return 8'h30 + 8'(v % 7'd10);
  endfunction

`ifdef REPORT_AUTO_SEC_EN
  logic [6:0] sec_q;

  // Tracks seconds even through reset so leaving reset never fakes a tick.
  always_ff @(posedge clk) begin
    sec_q <= seconds;
  end

  assign send_set = send | ((seconds != sec_q) & ~done);
`else
  assign send_set = send;
`endif

  assign done_set        = done & ~done_q;
  assign start_done_line = (state == IDLE) & done_pend;
  assign start_send_line = (state == IDLE) & ~done_pend & send_pend;
  assign start_line      = start_done_line | start_send_line;
  assign tick_end        = (tick_cnt == 16'(BIT_TICKS - 1));
  assign last_byte       = line_done ? (byte_idx == 3'd5) : (byte_idx == 3'd6);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      send_pend <= 1'b0;
      done_pend <= 1'b0;
      done_q    <= 1'b0;
      line_done <= 1'b0;
      tick_cnt  <= 16'd0;
      bit_idx   <= 3'd0;
      byte_idx  <= 3'd0;
    end else begin
      state     <= state_nxt;
      done_q    <= done;
      // A new request on the same edge a line starts must survive the clear.
      send_pend <= (send_pend & ~start_send_line) | send_set;
      done_pend <= (done_pend & ~start_done_line) | done_set;
      if (start_line) begin
        line_done <= done_pend;
        tick_cnt  <= 16'd0;
        bit_idx   <= 3'd0;
        byte_idx  <= 3'd0;
      end else if (state != IDLE) begin
        if (tick_end) begin
          tick_cnt <= 16'd0;
          if (state == DATA) begin
            bit_idx <= bit_idx + 3'd1;
          end
          if ((state == STOP) && !last_byte) begin
            byte_idx <= byte_idx + 3'd1;
          end
        end else begin
          tick_cnt <= tick_cnt + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (start_send_line) begin
      min_snap <= sat99(minutes);
      sec_snap <= sat99(seconds);
    end
  end

  always_comb begin
    cur_byte = 8'h0A;
    if (line_done) begin
      case (byte_idx)
        3'd0:    cur_byte = 8'h44;
        3'd1:    cur_byte = 8'h4F;
        3'd2:    cur_byte = 8'h4E;
        3'd3:    cur_byte = 8'h45;
        3'd4:    cur_byte = 8'h0D;
        default: cur_byte = 8'h0A;
      endcase
    end else begin
      case (byte_idx)
        3'd0:    cur_byte = ascii_tens(min_snap);
        3'd1:    cur_byte = ascii_ones(min_snap);
        3'd2:    cur_byte = 8'h3A;
        3'd3:    cur_byte = ascii_tens(sec_snap);
        3'd4:    cur_byte = ascii_ones(sec_snap);
        3'd5:    cur_byte = 8'h0D;
        default: cur_byte = 8'h0A;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    tx        = 1'b1;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (start_line) state_nxt = START;
      end
      START: begin
        tx   = 1'b0;
        busy = 1'b1;
        if (tick_end) state_nxt = DATA;
      end
      DATA: begin
        tx   = cur_byte[bit_idx];
        busy = 1'b1;
        if (tick_end && (bit_idx == 3'd7)) state_nxt = STOP;
      end
      STOP: begin
        busy = 1'b1;
        if (tick_end) state_nxt = last_byte ? IDLE : START;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_time_reporter.sv
// Directed self-checking bench for uart_time_reporter with BIT_TICKS=4.
module tb_uart_time_reporter;

  localparam int BT = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] minutes;
  logic [6:0] seconds;
  logic       done;
  logic       send;
  logic       tx;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;

  int busy_run = 0, last_busy_run = 0, low_run = 0, last_gap = 0;

  logic [7:0] exp_st   [7] = '{8'h32, 8'h35, 8'h3A, 8'h30, 8'h37, 8'h0D, 8'h0A};
  logic [7:0] exp_sat  [7] = '{8'h39, 8'h39, 8'h3A, 8'h35, 8'h39, 8'h0D, 8'h0A};
  logic [7:0] exp_done [6] = '{8'h44, 8'h4F, 8'h4E, 8'h45, 8'h0D, 8'h0A};
  logic [7:0] exp_pri  [7] = '{8'h30, 8'h35, 8'h3A, 8'h33, 8'h30, 8'h0D, 8'h0A};

  uart_time_reporter #(.BIT_TICKS(BT)) dut (
    .clk     (clk),
    .reset   (reset),
    .minutes (minutes),
    .seconds (seconds),
    .done    (done),
    .send    (send),
    .tx      (tx),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (busy) begin
      if (low_run != 0) begin
        last_gap <= low_run;
        low_run  <= 0;
      end
      busy_run <= busy_run + 1;
    end else begin
      if (busy_run != 0) begin
        last_busy_run <= busy_run;
        busy_run      <= 0;
      end
      low_run <= low_run + 1;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time exceeded, got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_send();
    send = 1'b1;
    @(negedge clk);
    send = 1'b0;
  endtask

  // Waits for a start bit, then samples each bit at its centre.
  task automatic recv_byte(output logic [7:0] b, output bit ok);
    int w;
    ok = 1'b1;
    b  = 8'h00;
    w  = 0;
    while (tx !== 1'b0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (tx !== 1'b0) begin
      ok = 1'b0;
      return;
    end
    repeat (BT / 2) @(negedge clk);
    if (tx !== 1'b0) ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (BT) @(negedge clk);
      b[i] = tx;
    end
    repeat (BT) @(negedge clk);
    if (tx !== 1'b1) ok = 1'b0;
  endtask

  task automatic test_reset_idle();
    bit tx_bad, busy_bad;
    minutes = 7'd0; seconds = 7'd0; done = 1'b0; send = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    tx_bad = 1'b0; busy_bad = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) tx_bad = 1'b1;
      if (busy !== 1'b0) busy_bad = 1'b1;
    end
    n_cmp++;
    if (tx_bad) begin
      n_err++;
      $display("FAIL idle_tx: tx left idle-high after reset, want 1 throughout");
    end
    n_cmp++;
    if (busy_bad) begin
      n_err++;
      $display("FAIL idle_busy: busy asserted after reset, want 0 throughout");
    end
  endtask

  task automatic test_status_line();
    logic [7:0] b;
    bit ok;
    minutes = 7'd25; seconds = 7'd7;
    do_reset();
    pulse_send();
    n_cmp++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL latency_k: tx=%b busy=%b, want tx=1 busy=0", tx, busy);
    end
    @(negedge clk);
    n_cmp++;
    if (tx !== 1'b0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL latency_k1: tx=%b busy=%b, want tx=0 busy=1", tx, busy);
    end
    for (int i = 0; i < 7; i++) begin
      recv_byte(b, ok);
      n_cmp++;
      if (!ok || b !== exp_st[i]) begin
        n_err++;
        $display("FAIL status_byte%0d: got %h (frame ok=%0d), want %h", i, b, ok, exp_st[i]);
      end
    end
    repeat (6) @(negedge clk);
    n_cmp++;
    if (last_busy_run !== 70 * BT) begin
      n_err++;
      $display("FAIL status_busy_len: got %0d cycles, want %0d", last_busy_run, 70 * BT);
    end
  endtask

  task automatic test_saturation();
    logic [7:0] b;
    bit ok;
    minutes = 7'd120; seconds = 7'd59;
    do_reset();
    pulse_send();
    for (int i = 0; i < 7; i++) begin
      recv_byte(b, ok);
      if (i == 1) seconds = 7'd0;
      n_cmp++;
      if (!ok || b !== exp_sat[i]) begin
        n_err++;
        $display("FAIL sat_byte%0d: got %h (frame ok=%0d), want %h", i, b, ok, exp_sat[i]);
      end
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_priority();
    logic [7:0] b;
    bit ok, quiet_bad;
    minutes = 7'd5; seconds = 7'd30; done = 1'b0;
    do_reset();
    send = 1'b1; done = 1'b1;
    @(negedge clk);
    send = 1'b0;
    for (int i = 0; i < 6; i++) begin
      recv_byte(b, ok);
      n_cmp++;
      if (!ok || b !== exp_done[i]) begin
        n_err++;
        $display("FAIL done_byte%0d: got %h (frame ok=%0d), want %h", i, b, ok, exp_done[i]);
      end
      if (i == 1 || i == 3) pulse_send();
    end
    for (int i = 0; i < 7; i++) begin
      recv_byte(b, ok);
      n_cmp++;
      if (!ok || b !== exp_pri[i]) begin
        n_err++;
        $display("FAIL prio_status_byte%0d: got %h (frame ok=%0d), want %h", i, b, ok, exp_pri[i]);
      end
      if (i == 0) begin
        n_cmp++;
        if (last_gap !== 1) begin
          n_err++;
          $display("FAIL line_gap: busy low for %0d cycles, want 1", last_gap);
        end
        n_cmp++;
        if (last_busy_run !== 60 * BT) begin
          n_err++;
          $display("FAIL done_busy_len: got %0d cycles, want %0d", last_busy_run, 60 * BT);
        end
      end
    end
    quiet_bad = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || (i > 4 && busy !== 1'b0)) quiet_bad = 1'b1;
    end
    n_cmp++;
    if (quiet_bad) begin
      n_err++;
      $display("FAIL coalesce: extra output after the single status line, want idle");
    end
    done = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b;
    bit ok, quiet_bad;
    minutes = 7'd12; seconds = 7'd34;
    do_reset();
    pulse_send();
    recv_byte(b, ok);
    n_cmp++;
    if (!ok || b !== 8'h31) begin
      n_err++;
      $display("FAIL midrst_byte0: got %h (frame ok=%0d), want 31", b, ok);
    end
    pulse_send();
    @(negedge clk);
    repeat (BT + 3 * BT) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_cmp++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_next: tx=%b busy=%b, want tx=1 busy=0", tx, busy);
    end
    quiet_bad = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) quiet_bad = 1'b1;
    end
    n_cmp++;
    if (quiet_bad) begin
      n_err++;
      $display("FAIL midrst_quiet: output after reset with no new request, want idle");
    end
  endtask

  task automatic test_auto_sec();
    logic [7:0] b;
    bit ok;
    logic [6:0] steps [3] = '{7'd10, 7'd9, 7'd8};
    logic [7:0] sec_t [3] = '{8'h31, 8'h30, 8'h30};
    logic [7:0] sec_o [3] = '{8'h30, 8'h39, 8'h38};
    logic [7:0] exp_line [7];
    int lows;
    minutes = 7'd1; seconds = 7'd30; done = 1'b0;
    do_reset();
    for (int s = 0; s < 3; s++) begin
      seconds = steps[s];
`ifdef REPORT_AUTO_SEC_EN
      exp_line = '{8'h30, 8'h31, 8'h3A, sec_t[s], sec_o[s], 8'h0D, 8'h0A};
      for (int i = 0; i < 7; i++) begin
        recv_byte(b, ok);
        n_cmp++;
        if (!ok || b !== exp_line[i]) begin
          n_err++;
          $display("FAIL auto_line%0d_byte%0d: got %h (frame ok=%0d), want %h", s, i, b, ok, exp_line[i]);
        end
      end
      repeat (10) @(negedge clk);
`else
      exp_line = '{8'h30, 8'h31, 8'h3A, sec_t[s], sec_o[s], 8'h0D, 8'h0A};
      lows = 0;
      for (int i = 0; i < 300; i++) begin
        @(negedge clk);
        if (tx !== 1'b1 || busy !== 1'b0) lows++;
      end
      n_cmp++;
      if (lows != 0) begin
        n_err++;
        $display("FAIL auto_off_step%0d: %0d active cycles (line would be %h%h), want 0", s, lows, exp_line[3], exp_line[4]);
      end
`endif
    end
  endtask

  initial begin
    reset = 1'b1; send = 1'b0; done = 1'b0; minutes = 7'd0; seconds = 7'd0;
    test_reset_idle();
    test_status_line();
    test_saturation();
    test_priority();
    test_reset_mid_frame();
    test_auto_sec();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_time_reporter.md
# uart_time_reporter

Transmit-side companion to the pomodoro UART command path. It serialises the countdown state back to the terminal as 8N1 ASCII lines on `tx`. A status line has the form "MM:SS\r\n" and the completion line is "DONE\r\n". It sits beside `timer_control` and takes that block's `minutes`, `seconds` and `done` outputs directly, plus a request pulse from a debounced button edge.

## Interface
- `BIT_TICKS`, default 10416: clock cycles per UART bit. The default gives 9600 baud at 100 MHz. Legal range is 2..65535.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `minutes`  in  7  remaining minutes, binary.
- `seconds`  in  7  remaining seconds, binary.
- `done`  in  1  level from `timer_control`; its rising edge requests a DONE line.
- `send`  in  1  single-cycle pulse that requests a status line.
- `tx`  out  1  UART serial output; idle high.
- `busy`  out  1  high while any line is being transmitted.

## Operation
- Request capture:
  - `send_pend` sets when `send`=1.
  - `done_pend` sets on a `done` 0->1 transition, detected with a registered `done_q`.
  - Each pending flag is one deep. Repeated requests while the flag is set coalesce into the one already pending.
- Arbitration in IDLE: if `done_pend` is set, start the DONE line; otherwise, if `send_pend` is set, start the status line. The flag for the line being started is cleared when that line starts.
- Snapshot: `minutes` and `seconds` are latched at status-line start and not at request time. Input changes during a line do not alter the bytes being sent.
- Digit encoding:
  - A value >99 saturates to 99.
  - tens = v/10 and ones = v%10, computed combinationally from the snapshot.
  - ASCII digit = 8'h30 + digit.
- Status bytes, index 0..6: tens(m), ones(m), 8'h3A, tens(s), ones(s), 8'h0D, 8'h0A.
- DONE bytes, index 0..5: 8'h44, 8'h4F, 8'h4E, 8'h45, 8'h0D, 8'h0A.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START when a line begins. Byte index is set to 0 and `busy` goes to 1.
  - START: `tx`=0 for BIT_TICKS cycles, then -> DATA.
  - DATA: 8 bits, LSB first, each held BIT_TICKS cycles, then -> STOP.
  - STOP: `tx`=1 for BIT_TICKS cycles. After STOP, go to START with index+1 if bytes remain; otherwise go to IDLE.
- Bytes within a line are back-to-back, with no idle gap between frames.

## Timing
- Reset values: `tx`=1, `busy`=0, FSM=IDLE, pending flags=0, `done_q`=0, all counters=0.
- Reset mid-frame: on the cycle after `reset` is sampled high, `tx`=1 and `busy`=0. The frame is truncated and both pending flags are cleared.
- Request latency:
  - A request sampled at edge k while IDLE makes `tx`=0 and `busy`=1 from edge k+1.
  - The request flag registers at edge k and FSM entry happens at edge k+1.
  - Each bit is exactly BIT_TICKS cycles. A frame is 10*BIT_TICKS cycles.
- Line durations: a status line is 70*BIT_TICKS cycles and a DONE line is 60*BIT_TICKS cycles.
- End of line: `busy` drops on the edge that ends the last stop bit, and the FSM returns to IDLE on that same edge.
  - If a pending flag is set, the next line's start bit begins on the following edge.
  - `busy` is therefore low for exactly one cycle between lines.
- Simultaneous events: `send` and a `done` rise in the same cycle set both flags. The DONE line goes first and the status line follows.
- A request arriving while `busy`=1 is never lost. It is serviced after the current line.
- Bit counter width is 16 bits. The bit-period counter runs 0..BIT_TICKS-1 and then wraps to 0.

## Configuration
- Macro `REPORT_AUTO_SEC_EN`.
- When defined:
  - A registered copy of `seconds` is kept.
  - Any change in `seconds` while `done`=0 sets `send_pend`, exactly as a `send` pulse would. This gives one automatic status line per timer tick.
  - The `send` input remains functional.
- When undefined: the seconds-compare logic is absent, and status lines are sent only on `send`.

## Test plan
- Idle after reset, with BIT_TICKS=4:
  - Stimulus: assert `reset` for 2 cycles, then hold 100 cycles with no stimulus.
  - Required: `tx`=1 and `busy`=0 throughout.
- Status line:
  - Stimulus: minutes=25, seconds=7, one `send` pulse.
  - Required: the decoded bytes are 32 35 3A 30 37 0D 0A. Each bit is 4 cycles. `busy` is high for 280 cycles.
- Saturation and snapshot:
  - Stimulus: minutes=120, seconds=59, `send`; change seconds to 0 at byte 2.
  - Required: the line is "99:59\r\n".
- Priority and coalescing:
  - Stimulus: pulse `send` and raise `done` in the same cycle, then pulse `send` twice more during the DONE line.
  - Required: "DONE\r\n" is sent, then exactly one status line. `busy` has a one-cycle low gap between the two lines.
- Reset mid-frame:
  - Stimulus: assert `reset` during the DATA bit 3 of byte 1.
  - Required: `tx`=1 and `busy`=0 on the next cycle, and no further output with no new request.
- With `REPORT_AUTO_SEC_EN` defined:
  - Stimulus: step seconds 10->9->8, with each step spaced more than 280 cycles apart.
  - Required: three status lines, ending in "09" and "08" for the second and third.
  - With the macro undefined, the same stimulus produces no output.
